counter_timer_chainable: RTL and testbench
==========================================

// Module: counter_timer_chainable
// PURPOSE
//  Memory-mapped 32-bit counter/timer in the management SoC, driven by firmware under test.
//  Firmware programs it, and the timer2 checkpoint flow reads its count and mirrors it onto mprj_io.
//  Two instances chain into one 64-bit timer: the lower instance strobes the upper; the upper stops the lower.
//  It counts up or down, continuous or one-shot, and emits an IRQ pulse at terminal count.
// PARAMETERS
//  WIDTH      32   counter, limit and value register width (multiple of 8)
// PORTS
//  clkin        in   1        system clock; all state on rising edge
//  resetn       in   1        asynchronous active-low reset
//  reg_cfg_we   in   1        write strobe, config register
//  reg_cfg_di   in   5        config write data {irq_ena,chain,updown,oneshot,enable}
//  reg_cfg_do   out  5        config readback
//  reg_dat_we   in   WIDTH/8  byte write enables, limit/reload register
//  reg_dat_di   in   WIDTH    limit write data
//  reg_dat_do   out  WIDTH    limit readback
//  reg_val_we   in   WIDTH/8  byte write enables, current value
//  reg_val_di   in   WIDTH    value write data
//  reg_val_do   out  WIDTH    current counter value
//  enable_in    in   1        chain: enable of the paired (lower) instance
//  strobe_in    in   1        chain: terminal pulse from the lower instance
//  stop_in      in   1        chain: one-shot stop from the upper instance
//  enable_out   out  1        cfg.enable, to the paired instance
//  strobe       out  1        1-cycle terminal-count pulse
//  stop_out     out  1        one-shot terminated, level
//  irq_out      out  1        1-cycle interrupt pulse
// BEHAVIOUR
//  Reset: cfg=0, dat=0, val=0, strobe=0, stop_out=0, irq_out=0. enable_out follows cfg, so it resets to 0.
//  Advance condition `adv`:
//   - chain=0: adv = enable & ~stop_in.
//   - chain=1: adv = enable & enable_in & strobe_in & ~stop_in.
//   - adv is always forced to 0 while stop_out=1.
//  Down count (updown=0), on an adv cycle:
//   - val!=0: val <= val-1.
//   - val==0 is terminal: continuous -> val <= dat; one-shot -> val holds 0 and stop_out <= 1.
//  Up count (updown=1), on an adv cycle:
//   - val!=dat: val <= val+1 (mod 2^WIDTH).
//   - val==dat is terminal: continuous -> val <= 0; one-shot -> val holds and stop_out <= 1.
//  Terminal event:
//   - strobe=1 for exactly the cycle after the adv cycle that met terminal; all outputs registered.
//   - irq_out=1 on the same cycle if irq_ena; otherwise 0.
//  Latency: register write at edge N is visible on *_do after edge N. Count takes effect the cycle after adv.
//  Simultaneous val write and adv: per-byte, written bytes take di; unwritten bytes take the counted value.
//   No terminal event fires that cycle.
//  Any cfg write clears stop_out and restarts counting from current val.
//  Writing enable=0 freezes val immediately and clears no other state.
//  dat=0 in up mode: terminal on every adv; val stays 0; strobe every adv cycle.
//  stop_in=1 freezes val without setting stop_out.
//  Reset mid-count returns to reset values on the same clkin-independent edge of resetn.
//  Readback is combinational from registers (no read side effects).
// STRUCTURE
//  Shared package ct_pkg:
//   - cfg bit index constants CT_ENABLE=0, CT_ONESHOT=1, CT_UPDOWN=2, CT_CHAIN=3, CT_IRQENA=4.
//   - CT_CFG_W=5.
//   - Later CPU-side register offsets: value 0x0, limit 0x4, cfg 0x8.
//  One sub-module is natural: ct_byte_reg (WIDTH-bit register with per-byte write enable and load-value merge).
//   It is used for dat and val.
//  Terminal detect, adv logic and strobe/irq/stop flops stay in the top module.
// TESTING
//  1 Down continuous:
//   - Stimulus: dat=5, val=5, cfg=enable|irq_ena.
//   - Response: val 5,4,..0, then 5; strobe and irq_out pulse once per 6 cycles; period exactly 6.
//  2 Up one-shot:
//   - Stimulus: dat=0x19, val=0, cfg=enable|updown|oneshot.
//   - Response: val stops at 0x19; stop_out=1; single strobe; holds 0x19 for 100 cycles.
//  3 Chain:
//   - Stimulus: lower dat=0x0f continuous down, with strobe->upper strobe_in; upper down from 0x0f, chain=1.
//   - Response: upper decrements once per 16 lower cycles; upper reads 0x0f before first lower terminal.
//  4 Stop propagation:
//   - Stimulus: upper one-shot reaching 0, with upper stop_out wired to lower stop_in.
//   - Response: lower val frozen on the next cycle and stays unchanged.
//  5 Write collision:
//   - Stimulus: counting down at val=0x12bd; same cycle write reg_val_we=4'b0001, di=0xbc.
//   - Response: val=0x12bc next cycle; no strobe that cycle.
//  6 Reset mid-count:
//   - Stimulus: assert resetn=0 asynchronously between edges while val=0x259.
//   - Response: all outputs 0 immediately; no strobe after release until re-configured.

Source files
------------

// File: rtl/ct_pkg.sv
// Shared definitions for the chainable counter/timer: config bit positions,
// config width and the CPU-side register offsets.
package ct_pkg;

   localparam int CT_ENABLE  = 0;
   localparam int CT_ONESHOT = 1;
   localparam int CT_UPDOWN  = 2;
   localparam int CT_CHAIN   = 3;
   localparam int CT_IRQENA  = 4;
   localparam int CT_CFG_W   = 5;

   // Byte offsets seen by firmware once the block sits behind a bus decoder.
   localparam logic [3:0] CT_OFS_VALUE = 4'h0;
   localparam logic [3:0] CT_OFS_LIMIT = 4'h4;
   localparam logic [3:0] CT_OFS_CFG   = 4'h8;

endpackage

// File: rtl/counter_timer_chainable_if.sv
// Register-side bus of the counter/timer: config, limit and value write ports
// plus their combinational readbacks.
interface counter_timer_chainable_if
   import ct_pkg::*;
#(
   parameter int WIDTH = 32
);

   logic                  reg_cfg_we;
   logic [CT_CFG_W-1:0]   reg_cfg_di;
   logic [CT_CFG_W-1:0]   reg_cfg_do;
   logic [WIDTH/8-1:0]    reg_dat_we;
   logic [WIDTH-1:0]      reg_dat_di;
   logic [WIDTH-1:0]      reg_dat_do;
   logic [WIDTH/8-1:0]    reg_val_we;
   logic [WIDTH-1:0]      reg_val_di;
   logic [WIDTH-1:0]      reg_val_do;

   modport master (
      output reg_cfg_we, reg_cfg_di, reg_dat_we, reg_dat_di, reg_val_we, reg_val_di,
      input  reg_cfg_do, reg_dat_do, reg_val_do
   );

   modport slave (
      input  reg_cfg_we, reg_cfg_di, reg_dat_we, reg_dat_di, reg_val_we, reg_val_di,
      output reg_cfg_do, reg_dat_do, reg_val_do
   );

endinterface

// File: rtl/ct_byte_reg.sv
// WIDTH-bit register with per-byte write enables; bytes not written take the
// load value when load_i is set, otherwise they hold.
module ct_byte_reg #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [WIDTH/8-1:0] we_i,
   input  logic [WIDTH-1:0]   wdata_i,
   input  logic               load_i,
   input  logic [WIDTH-1:0]   load_val_i,
   output logic [WIDTH-1:0]   q_o
);

   localparam int NB = WIDTH / 8;

   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] q_d;

   // NOTE: q_d gets a full default before the per-byte overrides, so no path leaves it unassigned (no latch).
   always_comb begin
      q_d = q_q;
      for (int b = 0; b < NB; b++) begin
         if (we_i[b]) begin
            q_d[b*8 +: 8] = wdata_i[b*8 +: 8];
         end else if (load_i) begin
            q_d[b*8 +: 8] = load_val_i[b*8 +: 8];
         end
      end
   end

   // NOTE: this is a plain flop bank, not a RAM, so it carries an asynchronous reset like any other state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q_o = q_q;

endmodule

// File: rtl/counter_timer_chainable.sv
// 32-bit up/down, continuous/one-shot counter/timer; two instances chain into a
// 64-bit timer via the enable/strobe/stop side ports.
module counter_timer_chainable
   import ct_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic                        clkin,
   input  logic                        resetn,
   counter_timer_chainable_if.slave    bus,
   input  logic                        enable_in,
   input  logic                        strobe_in,
   input  logic                        stop_in,
   output logic                        enable_out,
   output logic                        strobe,
   output logic                        stop_out,
   output logic                        irq_out
);

   logic [CT_CFG_W-1:0] cfg_q;
   logic [WIDTH-1:0]    dat_q;
   logic [WIDTH-1:0]    val_q;
   logic [WIDTH-1:0]    count_d;
   logic                stop_q;
   logic                stop_d;
   logic                strobe_q;
   logic                irq_q;
   logic                adv;
   logic                at_term;
   logic                term_evt;

   // In chain mode the upper half only moves on the lower half's terminal pulse.
   always_comb begin
      adv = cfg_q[CT_ENABLE] & ~stop_in & ~stop_q &
            (~cfg_q[CT_CHAIN] | (enable_in & strobe_in));
   end

   always_comb begin
      at_term = cfg_q[CT_UPDOWN] ? (val_q == dat_q) : (val_q == '0);
      count_d = val_q;
      if (adv) begin
         if (cfg_q[CT_UPDOWN]) begin
            if (!at_term) begin
               count_d = val_q + WIDTH'(1);
            end else if (!cfg_q[CT_ONESHOT]) begin
               count_d = '0;
            end
         end else begin
            if (!at_term) begin
               count_d = val_q - WIDTH'(1);
            end else if (!cfg_q[CT_ONESHOT]) begin
               count_d = dat_q;
            end
         end
      end
      // A firmware write to the value register masks the terminal event.
      term_evt = adv & at_term & ~(|bus.reg_val_we);
      stop_d   = stop_q;
      if (term_evt && cfg_q[CT_ONESHOT]) begin
         stop_d = 1'b1;
      end
      if (bus.reg_cfg_we) begin
         stop_d = 1'b0;
      end
   end

   // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clkin or negedge resetn) begin
      if (!resetn) begin
         cfg_q    <= '0;
         stop_q   <= 1'b0;
         strobe_q <= 1'b0;
         irq_q    <= 1'b0;
      end else begin
         if (bus.reg_cfg_we) begin
            cfg_q <= bus.reg_cfg_di;
         end
         stop_q   <= stop_d;
         strobe_q <= term_evt;
         irq_q    <= term_evt & cfg_q[CT_IRQENA];
      end
   end

   ct_byte_reg #(.WIDTH(WIDTH)) u_dat (
      .clk        (clkin),
      .rst_n      (resetn),
      .we_i       (bus.reg_dat_we),
      .wdata_i    (bus.reg_dat_di),
      .load_i     (1'b0),
      .load_val_i ('0),
      .q_o        (dat_q)
   );

   ct_byte_reg #(.WIDTH(WIDTH)) u_val (
      .clk        (clkin),
      .rst_n      (resetn),
      .we_i       (bus.reg_val_we),
      .wdata_i    (bus.reg_val_di),
      .load_i     (adv),
      .load_val_i (count_d),
      .q_o        (val_q)
   );

   assign bus.reg_cfg_do = cfg_q;
   assign bus.reg_dat_do = dat_q;
   assign bus.reg_val_do = val_q;
   assign enable_out     = cfg_q[CT_ENABLE];
   assign strobe         = strobe_q;
   assign stop_out       = stop_q;
   assign irq_out        = irq_q;

endmodule

// File: tb/tb_counter_timer_chainable.sv
// Directed and randomized bench for counter_timer_chainable: two chained
// instances, closed-form expectations for directed steps, spec-level model for random.
module tb_counter_timer_chainable;
   import ct_pkg::*;

   localparam int W  = 32;
   localparam int NB = W / 8;

   logic clkin  = 1'b0;
   logic resetn = 1'b0;
   always #5 clkin = ~clkin;

   counter_timer_chainable_if #(.WIDTH(W)) bus_lo ();
   counter_timer_chainable_if #(.WIDTH(W)) bus_hi ();

   logic lo_enable_in, lo_strobe_in, tb_lo_stop, stop_link;
   logic lo_stop_in;
   logic lo_enable_out, lo_strobe, lo_stop_out, lo_irq;
   logic hi_enable_out, hi_strobe, hi_stop_out, hi_irq;

   assign lo_stop_in = tb_lo_stop | (stop_link & hi_stop_out);

   counter_timer_chainable #(.WIDTH(W)) u_lo (
      .clkin (clkin), .resetn (resetn), .bus (bus_lo.slave),
      .enable_in (lo_enable_in), .strobe_in (lo_strobe_in), .stop_in (lo_stop_in),
      .enable_out (lo_enable_out), .strobe (lo_strobe), .stop_out (lo_stop_out), .irq_out (lo_irq)
   );

   counter_timer_chainable #(.WIDTH(W)) u_hi (
      .clkin (clkin), .resetn (resetn), .bus (bus_hi.slave),
      .enable_in (lo_enable_out), .strobe_in (lo_strobe), .stop_in (1'b0),
      .enable_out (hi_enable_out), .strobe (hi_strobe), .stop_out (hi_stop_out), .irq_out (hi_irq)
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clkin);
      @(negedge clkin);
   endtask

   task automatic clear_we();
      bus_lo.reg_cfg_we = 1'b0; bus_lo.reg_dat_we = '0; bus_lo.reg_val_we = '0;
      bus_hi.reg_cfg_we = 1'b0; bus_hi.reg_dat_we = '0; bus_hi.reg_val_we = '0;
   endtask

   task automatic prog_lo(input logic [4:0] cfg, input logic [31:0] dat, input logic [31:0] val);
      bus_lo.reg_cfg_we = 1'b1; bus_lo.reg_cfg_di = cfg;
      bus_lo.reg_dat_we = '1;   bus_lo.reg_dat_di = dat;
      bus_lo.reg_val_we = '1;   bus_lo.reg_val_di = val;
   endtask

   task automatic prog_hi(input logic [4:0] cfg, input logic [31:0] dat, input logic [31:0] val);
      bus_hi.reg_cfg_we = 1'b1; bus_hi.reg_cfg_di = cfg;
      bus_hi.reg_dat_we = '1;   bus_hi.reg_dat_di = dat;
      bus_hi.reg_val_we = '1;   bus_hi.reg_val_di = val;
   endtask

   // Behavioural model of one instance, written from the counting rules.
   typedef struct {
      logic [4:0]  cfg;
      logic [31:0] dat;
      logic [31:0] val;
      logic        stop;
      logic        strobe;
      logic        irq;
   } mdl_t;

   function automatic logic [31:0] merge(input logic [3:0] we, input logic [31:0] di,
                                         input logic [31:0] base);
      logic [31:0] r = base;
      for (int b = 0; b < NB; b++) if (we[b]) r[b*8 +: 8] = di[b*8 +: 8];
      return r;
   endfunction

   function automatic mdl_t mdl_next(input mdl_t s, input logic cwe, input logic [4:0] cdi,
                                     input logic [3:0] dwe, input logic [31:0] ddi,
                                     input logic [3:0] vwe, input logic [31:0] vdi,
                                     input logic ein, input logic sin, input logic stp);
      mdl_t n = s;
      bit go, hit;
      logic [31:0] counted = s.val;
      go  = s.cfg[CT_ENABLE] && !stp && !s.stop && (!s.cfg[CT_CHAIN] || (ein && sin));
      hit = 1'b0;
      if (go) begin
         if (s.cfg[CT_UPDOWN]) begin
            hit     = (s.val == s.dat);
            counted = hit ? (s.cfg[CT_ONESHOT] ? s.val : 32'd0) : s.val + 32'd1;
         end else begin
            hit     = (s.val == 32'd0);
            counted = hit ? (s.cfg[CT_ONESHOT] ? 32'd0 : s.dat) : s.val - 32'd1;
         end
      end
      hit      = hit && (vwe == 4'h0);
      n.val    = merge(vwe, vdi, counted);
      n.dat    = merge(dwe, ddi, s.dat);
      n.cfg    = cwe ? cdi : s.cfg;
      n.strobe = hit;
      n.irq    = hit && s.cfg[CT_IRQENA];
      n.stop   = cwe ? 1'b0 : ((hit && s.cfg[CT_ONESHOT]) ? 1'b1 : s.stop);
      return n;
   endfunction

   initial begin
      mdl_t m;
      int strobes;
      logic cwe, ein, sin, stp;
      logic [4:0] cdi;
      logic [3:0] dwe, vwe;
      logic [31:0] ddi, vdi;

      clear_we();
      bus_lo.reg_cfg_di = '0; bus_lo.reg_dat_di = '0; bus_lo.reg_val_di = '0;
      bus_hi.reg_cfg_di = '0; bus_hi.reg_dat_di = '0; bus_hi.reg_val_di = '0;
      lo_enable_in = 1'b0; lo_strobe_in = 1'b0; tb_lo_stop = 1'b0; stop_link = 1'b0;

      // Reset state
      #3;
      chk("rst_val", bus_lo.reg_val_do, 0);
      chk("rst_cfg", bus_lo.reg_cfg_do, 0);
      chk("rst_dat", bus_lo.reg_dat_do, 0);
      chk("rst_outs", {lo_enable_out, lo_strobe, lo_stop_out, lo_irq}, 0);
      @(negedge clkin);
      resetn = 1'b1;
      step();

      // 1: down continuous, period 6
      prog_lo(5'h11, 32'd5, 32'd5);
      step(); clear_we();
      chk("t1_load", bus_lo.reg_val_do, 5);
      strobes = 0;
      for (int k = 1; k <= 18; k++) begin
         step();
         chk("t1_val", bus_lo.reg_val_do, (5 - (k % 6) + 6) % 6);
         chk("t1_strobe", lo_strobe, (k % 6) == 0);
         chk("t1_irq", lo_irq, (k % 6) == 0);
         if (lo_strobe) strobes++;
      end
      chk("t1_strobe_count", strobes, 3);

      // 2: up one-shot to 0x19
      prog_lo(5'h07, 32'h19, 32'h0);
      step(); clear_we();
      strobes = 0;
      for (int k = 1; k <= 126; k++) begin
         step();
         chk("t2_val", bus_lo.reg_val_do, (k < 25) ? k : 25);
         chk("t2_stop", lo_stop_out, k >= 26);
         chk("t2_irq", lo_irq, 0);
         if (lo_strobe) strobes++;
      end
      chk("t2_strobe_count", strobes, 1);

      // 3: 64-bit chain, upper moves once per 16 lower cycles
      prog_lo(5'h01, 32'h0f, 32'h0f);
      prog_hi(5'h09, 32'h0f, 32'h0f);
      step(); clear_we();
      chk("t3_hi_start", bus_hi.reg_val_do, 32'h0f);
      for (int k = 1; k <= 40; k++) begin
         step();
         chk("t3_lo_val", bus_lo.reg_val_do, (15 - (k % 16) + 16) % 16);
         chk("t3_lo_strobe", lo_strobe, (k % 16) == 0);
         chk("t3_hi_val", bus_hi.reg_val_do, 15 - (k - 1) / 16);
         chk("t3_hi_strobe", hi_strobe, 0);
      end

      // 4: upper one-shot stop freezes the lower instance
      stop_link = 1'b1;
      prog_lo(5'h01, 32'd3, 32'd3);
      prog_hi(5'h0b, 32'd0, 32'd1);
      step(); clear_we();
      for (int k = 1; k <= 40; k++) begin
         step();
         chk("t4_lo_val", bus_lo.reg_val_do, (k <= 9) ? (3 - (k % 4) + 4) % 4 : 2);
         chk("t4_lo_strobe", lo_strobe, (k == 4) || (k == 8));
         chk("t4_hi_val", bus_hi.reg_val_do, (k >= 5) ? 0 : 1);
         chk("t4_hi_stop", hi_stop_out, k >= 9);
         chk("t4_hi_strobe", hi_strobe, k == 9);
      end
      stop_link = 1'b0;
      prog_hi(5'h00, 32'd0, 32'd0);
      step(); clear_we();

      // 5: value write colliding with a count
      prog_lo(5'h11, 32'hffff, 32'h12be);
      step(); clear_we();
      step();
      chk("t5_pre", bus_lo.reg_val_do, 32'h12bd);
      bus_lo.reg_val_we = 4'b0001; bus_lo.reg_val_di = 32'hbc;
      step(); clear_we();
      chk("t5_val", bus_lo.reg_val_do, 32'h12bc);
      chk("t5_strobe", lo_strobe, 0);
      bus_lo.reg_val_we = '1; bus_lo.reg_val_di = 32'd1;
      step(); clear_we();
      step();
      chk("t5_zero", bus_lo.reg_val_do, 0);
      bus_lo.reg_val_we = 4'b0001; bus_lo.reg_val_di = 32'h55;
      step(); clear_we();
      chk("t5_term_val", bus_lo.reg_val_do, 32'hff55);
      chk("t5_term_strobe", lo_strobe, 0);
      chk("t5_term_irq", lo_irq, 0);
      step();
      chk("t5_after", bus_lo.reg_val_do, 32'hff54);

      // 6: asynchronous reset mid-count
      prog_lo(5'h11, 32'h300, 32'h259);
      step(); clear_we();
      chk("t6_pre", bus_lo.reg_val_do, 32'h259);
      #2 resetn = 1'b0;
      #1;
      chk("t6_val", bus_lo.reg_val_do, 0);
      chk("t6_cfg", bus_lo.reg_cfg_do, 0);
      chk("t6_dat", bus_lo.reg_dat_do, 0);
      chk("t6_outs", {lo_enable_out, lo_strobe, lo_stop_out, lo_irq}, 0);
      @(negedge clkin);
      #2 resetn = 1'b1;
      @(negedge clkin);
      for (int k = 0; k < 20; k++) begin
         step();
         chk("t6_idle_val", bus_lo.reg_val_do, 0);
         chk("t6_idle_strobe", lo_strobe, 0);
      end

      // Random traffic against the model
      m = '{cfg: '0, dat: '0, val: '0, stop: 1'b0, strobe: 1'b0, irq: 1'b0};
      for (int i = 0; i < 400; i++) begin
         cwe = ($urandom_range(0, 15) == 0);
         cdi = {1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
                1'($urandom_range(0, 7) != 0)};
         dwe = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
         ddi = 32'($urandom_range(0, 12));
         vwe = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
         vdi = 32'($urandom_range(0, 15));
         ein = ($urandom_range(0, 7) != 0);
         sin = 1'($urandom_range(0, 1));
         stp = ($urandom_range(0, 15) == 0);
         bus_lo.reg_cfg_we = cwe; bus_lo.reg_cfg_di = cdi;
         bus_lo.reg_dat_we = dwe; bus_lo.reg_dat_di = ddi;
         bus_lo.reg_val_we = vwe; bus_lo.reg_val_di = vdi;
         lo_enable_in = ein; lo_strobe_in = sin; tb_lo_stop = stp;
         m = mdl_next(m, cwe, cdi, dwe, ddi, vwe, vdi, ein, sin, stp);
         step(); clear_we();
         chk("rnd_val", bus_lo.reg_val_do, m.val);
         chk("rnd_dat", bus_lo.reg_dat_do, m.dat);
         chk("rnd_cfg", bus_lo.reg_cfg_do, m.cfg);
         chk("rnd_strobe", lo_strobe, m.strobe);
         chk("rnd_irq", lo_irq, m.irq);
         chk("rnd_stop", lo_stop_out, m.stop);
         chk("rnd_enable_out", lo_enable_out, m.cfg[CT_ENABLE]);
      end
      tb_lo_stop = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
